icache_fetch_responder: RTL and testbench

- Responder end of the core's instruction-fetch handshake: the core drives instrreq/instradr and waits while abort is high; this block returns instrF and hit.
- Direct-mapped instruction cache. LINES lines, 4 words per line.
- Misses refill a full line from a backing instruction memory over a simple req/valid beat interface.
- Sits between the pipelined core's fetch stage and instruction memory.

---
 rtl/icache_fetch_responder.sv | 147 ++++++++++++++
 tb/tb_icache_fetch_responder.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_fetch_responder.sv
// rtl/icache_fetch_responder.sv - direct-mapped 4-word-line instruction cache answering the core fetch handshake
// Optional hit/miss counters: define ICACHE_STATS_EN.
module icache_fetch_responder #(
    parameter int LINES = 16,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          instrreq,
    input  logic [AW-1:0] instradr,
    output logic [DW-1:0] instrF,
    output logic          hit,
    output logic          abort,
    input  logic          flush,
    output logic          memreq,
    output logic [AW-1:0] memadr,
    input  logic [DW-1:0] memrdata,
    input  logic          memvalid
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]   hitcnt,
    output logic [31:0]   misscnt
`endif
);
    localparam int IW = $clog2(LINES);
    localparam int TW = AW - 4 - IW;

    typedef enum logic [2:0] {IDLE, LOOKUP, REFILL, RESPOND, DRAIN} state_t;
    state_t state, state_next;

    logic [TW-1:0]    req_tag;
    logic [IW-1:0]    req_index;
    logic [1:0]       req_offset;
    logic [1:0]       beat;
    logic             flushed;
    logic [LINES-1:0] valid;
    logic [TW-1:0]    tags [LINES];
    logic [DW-1:0]    data [LINES][4];

    logic lookup_hit;
    logic beat_done;
    logic last_beat;

    // A flush in the lookup cycle forces a miss so stale data is never returned.
    assign lookup_hit = valid[req_index] && (tags[req_index] == req_tag) && !flush;
    assign beat_done  = (state == REFILL) && memreq && memvalid;
    assign last_beat  = beat_done && (beat == 2'd3);
    assign abort      = instrreq && (state != RESPOND);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (instrreq) state_next = LOOKUP;
            LOOKUP:  state_next = lookup_hit ? RESPOND : REFILL;
            REFILL:  if (last_beat) state_next = instrreq ? RESPOND : IDLE;
            RESPOND: if (!instrreq) state_next = DRAIN;
            DRAIN:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_tag    <= '0;
            req_index  <= '0;
            req_offset <= '0;
            memreq     <= 1'b0;
            memadr     <= '0;
            instrF     <= '0;
            hit        <= 1'b0;
            beat       <= '0;
            flushed    <= 1'b0;
            valid      <= '0;
        end else begin
            if (flush)
                valid <= '0;
            else if (last_beat && !flushed)
                valid[req_index] <= 1'b1;

            case (state)
                IDLE: begin
                    if (instrreq) begin
                        req_tag    <= instradr[AW-1:4+IW];
                        req_index  <= instradr[3+IW:4];
                        req_offset <= instradr[3:2];
                    end
                end
                LOOKUP: begin
                    if (lookup_hit) begin
                        instrF <= data[req_index][req_offset];
                        hit    <= 1'b1;
                    end else begin
                        beat    <= '0;
                        flushed <= 1'b0;
                        memreq  <= 1'b1;
                        memadr  <= {req_tag, req_index, 4'b0000};
                    end
                end
                REFILL: begin
                    if (flush) flushed <= 1'b1;
                    if (beat_done) begin
                        memadr <= memadr + AW'(4);
                        beat   <= beat + 2'd1;
                        if (beat == 2'd3) begin
                            memreq <= 1'b0;
                            if (instrreq) begin
                                // word 3 is still in flight on memrdata this cycle
                                instrF <= (req_offset == 2'd3) ? memrdata : data[req_index][req_offset];
                                hit    <= 1'b0;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (beat_done) begin
            data[req_index][beat] <= memrdata;
            if (beat == 2'd3) tags[req_index] <= req_tag;
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hitcnt  <= '0;
            misscnt <= '0;
        end else if (flush) begin
            hitcnt  <= '0;
            misscnt <= '0;
        end else if (state == LOOKUP) begin
            if (state_next == RESPOND) hitcnt  <= hitcnt + 32'd1;
            if (state_next == REFILL)  misscnt <= misscnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_icache_fetch_responder.sv
// tb/tb_icache_fetch_responder.sv - scoreboard bench for icache_fetch_responder
module tb_icache_fetch_responder;
    localparam int LINES = 16;
    localparam int IW    = $clog2(LINES);

    logic        clk = 1'b0;
    logic        reset;
    logic        instrreq;
    logic [31:0] instradr;
    logic [31:0] instrF;
    logic        hit;
    logic        abort;
    logic        flush;
    logic        memreq;
    logic [31:0] memadr;
    logic [31:0] memrdata;
    logic        memvalid;
`ifdef ICACHE_STATS_EN
    logic [31:0] hitcnt;
    logic [31:0] misscnt;
`endif

    int          checks = 0;
    int          errors = 0;
    int          mem_lat = 2;
    logic [32:0] exp_q[$];
    logic [31:0] beats[$];
    bit          mv[LINES];
    logic [31:0] mt[LINES];

    icache_fetch_responder #(.LINES(LINES), .AW(32), .DW(32)) dut (
        .clk(clk), .reset(reset), .instrreq(instrreq), .instradr(instradr),
        .instrF(instrF), .hit(hit), .abort(abort), .flush(flush),
        .memreq(memreq), .memadr(memadr), .memrdata(memrdata), .memvalid(memvalid)
`ifdef ICACHE_STATS_EN
        , .hitcnt(hitcnt), .misscnt(misscnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a >> 2) * 32'd3;
    endfunction

    function automatic int pick_lat();
        if (mem_lat < 0) return int'($urandom_range(0, 2));
        return mem_lat;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Backing memory: word address x3, configurable wait before each beat, stray memvalid when idle.
    initial begin
        int wc;
        wc = 0;
        memvalid = 1'b0;
        memrdata = '0;
        forever begin
            @(negedge clk);
            if (memreq === 1'b1 && reset === 1'b0) begin
                if (wc == 0) begin
                    memvalid = 1'b1;
                    memrdata = word_of(memadr);
                    beats.push_back(memadr);
                    wc = pick_lat();
                end else begin
                    memvalid = 1'b0;
                    memrdata = $urandom;
                    wc--;
                end
            end else begin
                memvalid = ($urandom_range(0, 3) == 0);
                memrdata = $urandom;
                wc = pick_lat();
            end
        end
    end

    // Response monitor: one pop per completed fetch.
    initial begin
        bit served;
        served = 0;
        forever begin
            @(negedge clk);
            if (instrreq === 1'b1 && abort === 1'b0 && reset === 1'b0) begin
                if (!served) begin
                    served = 1;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_response instrF=%0h hit=%0b expected none", instrF, hit);
                    end else begin
                        logic [32:0] e;
                        e = exp_q.pop_front();
                        check("response_instrF", instrF, e[31:0]);
                        check("response_hit", hit, e[32]);
                    end
                end
            end else if (instrreq !== 1'b1) begin
                served = 0;
            end
        end
    end

    task automatic pulse_flush();
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        foreach (mv[i]) mv[i] = 0;
    endtask

    // mode: 0 normal, 1 flush during refill, 2 abandon mid-refill, 3 reset mid-refill
    task automatic fetch(input logic [31:0] a, input int mode);
        int          idx;
        int          m;
        int          ac;
        bit          exp_hit;
        bit          fl;
        bit          done;
        logic [31:0] tg;
        logic [31:0] base;
        idx  = int'((a >> 4) % LINES);
        tg   = a >> (4 + IW);
        base = {a[31:4], 4'b0000};
        exp_hit = mv[idx] && (mt[idx] == tg);
        m = exp_hit ? 0 : mode;
        beats.delete();
        if (m < 2) exp_q.push_back({exp_hit, word_of(a)});
        @(posedge clk);
        #1;
        instradr = a;
        instrreq = 1'b1;
        ac = 0;
        fl = 0;
        done = 0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            if (m == 1 && !fl && memreq === 1'b1) begin
                flush = 1'b1;
                fl = 1;
            end else begin
                flush = 1'b0;
            end
            if (m >= 2 && beats.size() >= 2) done = 1;
            else if (m < 2 && abort === 1'b0) done = 1;
            else ac++;
        end
        flush = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL fetch_timeout addr=%0h actual=waiting expected=response", a);
        end
        if (m < 2) begin
            if (exp_hit) check("hit_latency", ac, 2);
            else if (mem_lat >= 0) check("miss_latency", ac, 2 + 4 * (mem_lat + 1));
            else check("miss_latency_min", (ac >= 6), 1);
            check("beat_count", beats.size(), exp_hit ? 0 : 4);
            if (!exp_hit && beats.size() == 4)
                for (int k = 0; k < 4; k++) check("beat_adr", beats[k], base + 32'(4 * k));
            @(posedge clk);
            #1;
            instrreq = 1'b0;
            repeat (2) @(posedge clk);
            if (!exp_hit) begin
                if (fl) foreach (mv[i]) mv[i] = 0;
                mv[idx] = !fl;
                mt[idx] = tg;
            end
        end else if (m == 2) begin
            @(posedge clk);
            #1;
            instrreq = 1'b0;
            for (int c = 0; c < 100; c++) begin
                @(negedge clk);
                if (memreq === 1'b0) break;
            end
            repeat (2) @(posedge clk);
            #1;
            check("abandon_abort", abort, 0);
            check("abandon_memreq", memreq, 0);
            check("abandon_beats", beats.size(), 4);
            mv[idx] = 1;
            mt[idx] = tg;
        end else begin
            @(posedge clk);
            #2;
            reset = 1'b1;
            #1;
            check("rst_memreq", memreq, 0);
            check("rst_hit", hit, 0);
            check("rst_instrF", instrF, 0);
            check("rst_abort_follows", abort, 1);
            instrreq = 1'b0;
            repeat (2) @(posedge clk);
            @(negedge clk);
            reset = 1'b0;
            foreach (mv[i]) mv[i] = 0;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        logic [31:0] a;
        reset = 1'b1;
        instrreq = 1'b0;
        instradr = '0;
        flush = 1'b0;
        foreach (mv[i]) begin
            mv[i] = 0;
            mt[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("reset_abort", abort, 0);
        check("reset_memreq", memreq, 0);
        check("reset_memadr", memadr, 0);
        check("reset_instrF", instrF, 0);
        check("reset_hit", hit, 0);
        instrreq = 1'b1;
        #1;
        check("reset_abort_follows", abort, 1);
        instrreq = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        mem_lat = 2;
        fetch(32'h0000_0008, 0);
        fetch(32'h0000_000C, 0);
        fetch(32'h0000_0000, 0);
        fetch(32'h0000_0100, 0);
        fetch(32'h0000_0000, 0);
        fetch(32'h0000_0020, 0);
        pulse_flush();
        fetch(32'h0000_0020, 0);
        fetch(32'h0000_0040, 1);
        fetch(32'h0000_0040, 0);
        fetch(32'h0000_0080, 2);
        fetch(32'h0000_0084, 0);
        fetch(32'h0000_00C0, 3);
        fetch(32'h0000_00C0, 0);

        mem_lat = -1;
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 7) == 0) a = $urandom;
            else a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 4) | 32'($urandom_range(0, 15));
            r = int'($urandom_range(0, 19));
            if (r < 2) begin
                pulse_flush();
                fetch(a, 0);
            end else if (r < 4) fetch(a, 1);
            else if (r < 6) fetch(a, 2);
            else if (r == 6) fetch(a, 3);
            else fetch(a, 0);
        end

        repeat (4) @(posedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
